alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, sets operand/result width in bits; legal range 8..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request; operands and opcode sampled in the same cycle.
REQ-005 SrcA  input  WIDTH  operand A.
REQ-006 SrcB  input  WIDTH  operand B.
REQ-007 ALUControl  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 MOV, 100 ORR, 101 EOR, 110 MUL, 111 reserved.
REQ-008 Busy  output  1  multi-cycle operation in progress; Start ignored while high.
REQ-009 Done  output  1  single-cycle pulse; ALU_Result/ALUFlags valid and updated this cycle.
REQ-010 ALU_Result  output  WIDTH  registered result, held until next Done.
REQ-011 ALUFlags  output  4  registered {N,Z,C,V}, held until next Done.

Function
REQ-012 States: IDLE, MUL; Start accepted only in IDLE.
REQ-013 Single-cycle ops (ADD, SUB, AND, MOV, ORR, EOR, reserved): Start in cycle T -> Done=1 in T+1, state stays IDLE, Busy stays 0.
REQ-014 Back-to-back single-cycle Starts in consecutive cycles yield Done in consecutive cycles, one result per request, none dropped.
REQ-015 Start coincident with a Done cycle (Busy=0) is accepted.
REQ-016 MUL: Start in T -> IDLE->MUL; radix-2 shift-add over WIDTH iterations; Done=1 in T+WIDTH; Busy=1 in T+1..T+WIDTH-1, 0 in T+WIDTH; MUL->IDLE on the edge that raises Done.
REQ-017 Start while Busy=1 ignored: no latch, no extra Done, in-flight result unaffected.
REQ-018 Operands/opcode latched at acceptance; SrcA/SrcB/ALUControl changes during MUL do not affect the result.
REQ-019 Arithmetic modulo 2^WIDTH; MUL returns low WIDTH bits of the unsigned product.
REQ-020 N = ALU_Result[WIDTH-1]; Z = (ALU_Result == 0).
REQ-021 ADD: C = carry out of bit WIDTH-1; V = signed overflow (operands same sign, result sign differs).
REQ-022 SUB: computed as A + ~B + 1; C = 1 when no borrow (A >= B unsigned); V = signed overflow.
REQ-023 AND, ORR, EOR, MOV (result = SrcB), MUL: C = 0, V = 0.
REQ-024 Reserved opcode 111: ALU_Result = 0, ALUFlags = {0,1,0,0}, timing per REQ-013.
REQ-025 Outputs change only on the cycle Done asserts (or reset); never mid-MUL.

Reset
REQ-026 reset_n low: immediately, independent of clk, ALU_Result=0, ALUFlags=0000, Done=0, Busy=0, state IDLE, iteration counter 0.
REQ-027 Reset mid-MUL aborts: no Done for the aborted request; after reset_n rises, first clk edge with Start accepts a new request.
REQ-028 Start held high during reset ignored; reset_n release treated as synchronous to clk by the integrator.

Configuration
REQ-029 Macro ALU_MULTICYCLE_MUL_EN defined: MUL state, shift-add datapath and counter compiled in, behaviour per REQ-016.
REQ-030 Macro undefined: no MUL hardware; opcode 110 behaves as reserved (REQ-024), Busy is constant 0.

Verification
REQ-031 WIDTH=32, ADD 0xFFFFFFFF + 0x00000001 -> Done at T+1, ALU_Result=0x00000000, ALUFlags NZCV=0110.
REQ-032 WIDTH=32, SUB 0x80000000 - 0x00000001 -> ALU_Result=0x7FFFFFFF, NZCV=0011; SUB 5-5 -> 0, NZCV=0110.
REQ-033 WIDTH=32, MUL_EN defined, MUL 0x00010003 x 0x00000007 -> Busy high T+1..T+31, Done at T+32, ALU_Result=0x00070015, NZCV=0000; Start pulsed in T+5 with ADD ignored.
REQ-034 Consecutive Starts AND 0xF0F0 & 0xFF00, ORR, EOR, MOV in T..T+3 -> Done in T+1..T+4, results 0xF000, then ORR/EOR/MOV values in order.
REQ-035 MUL started, reset_n low at T+10 for 2 cycles -> outputs 0 immediately, no Done through T+40; new ADD 2+3 after release -> 5, NZCV=0000.
REQ-036 MUL_EN undefined, opcode 110 with any operands -> Done at T+1, ALU_Result=0, NZCV=0100, Busy never 1.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered single-cycle ops plus an optional radix-2 shift-add multiplier.
// Define ALU_MULTICYCLE_MUL_EN to build the MUL state and datapath; otherwise opcode 110 acts as reserved.
//
// state  | meaning
// S_IDLE | ready; single-cycle ops complete in the cycle after Start
// S_MUL  | shift-add iterations in flight, Busy high, Start ignored
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [3:0]       ALUFlags
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_MOV = 3'b011;
    localparam logic [2:0] OP_ORR = 3'b100;
    localparam logic [2:0] OP_EOR = 3'b101;

    logic             accept;
    logic             single_fire;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign accept = Start && !Busy;

    // SUB shares the adder as A + ~B + 1, so carry-out doubles as "no borrow"
    always_comb begin
        is_sub  = (ALUControl == OP_SUB);
        b_eff   = is_sub ? ~SrcB : SrcB;
        sum     = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  alu_res = SrcA & SrcB;
            OP_MOV:  alu_res = SrcB;
            OP_ORR:  alu_res = SrcA | SrcB;
            OP_EOR:  alu_res = SrcA ^ SrcB;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULTICYCLE_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam int         CNT_W  = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_nxt;

    assign is_mul      = (ALUControl == OP_MUL);
    assign mul_start   = accept && is_mul;
    assign single_fire = accept && !is_mul;
    assign mul_done    = (state == S_MUL) && (cnt == '0);
    assign Busy        = (state == S_MUL);
    assign acc_nxt     = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_start) state_nxt = S_MUL;
            S_MUL:   if (cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // First iteration happens on the accepting edge; the remaining WIDTH-1 run in S_MUL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (mul_start) begin
            acc    <= SrcB[0] ? SrcA : '0;
            mcand  <= SrcA << 1;
            mplier <= SrcB >> 1;
            cnt    <= CNT_W'(WIDTH - 2);
        end else if (state == S_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end
`else
    assign Busy        = 1'b0;
    assign single_fire = accept;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Done       <= 1'b0;
            ALU_Result <= '0;
            ALUFlags   <= '0;
        end else begin
            Done <= 1'b0;
            if (single_fire) begin
                Done       <= 1'b1;
                ALU_Result <= alu_res;
                ALUFlags   <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
`ifdef ALU_MULTICYCLE_MUL_EN
            else if (mul_done) begin
                Done       <= 1'b1;
                ALU_Result <= acc_nxt;
                ALUFlags   <= {acc_nxt[WIDTH-1], (acc_nxt == '0), 1'b0, 1'b0};
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32); MUL checks compile in with ALU_MULTICYCLE_MUL_EN.
`timescale 1ns/1ps
module tb_alu_multicycle;
    localparam int W = 32;
`ifdef ALU_MULTICYCLE_MUL_EN
    localparam int MUL_LAT = W;
`else
    localparam int MUL_LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          Start;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic [2:0]    ALUControl;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  ALU_Result;
    logic [3:0]    ALUFlags;

    int            cyc;
    int            n_cmp;
    int            n_err;
    exp_t          q[$];
    exp_t          mon_e;
    logic [31:0]   held_res;
    logic [3:0]    held_flg;
    bit            mul_on;
    int            mul_t;
    int            k;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Start      (Start),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .Busy       (Busy),
        .Done       (Done),
        .ALU_Result (ALU_Result),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c;
        logic        v;
        longint      s;
        r = '0; c = 1'b0; v = 1'b0; s = 0;
        case (op)
            3'b000: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            3'b001: begin
                r = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            3'b010: r = a & b;
            3'b011: r = b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
`ifdef ALU_MULTICYCLE_MUL_EN
            3'b110: begin
                logic [63:0] p;
                p = {32'h0, a} * {32'h0, b};
                r = p[31:0];
            end
`endif
            default: r = '0;
        endcase
        return {r[31], (r == 32'h0), c, v, r};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic bit busy_exp();
        return mul_on && (cyc > mul_t) && (cyc < mul_t + W);
    endfunction

    // Drive one accepted request for a single cycle and record what it must produce
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [35:0] exp);
        exp_t e;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        Start      = 1'b1;
        e.due = cyc + ((op == 3'b110) ? MUL_LAT : 1);
        e.res = exp[31:0];
        e.flg = exp[35:32];
        q.push_back(e);
        if (op == 3'b110 && MUL_LAT > 1) begin
            mul_on = 1'b1;
            mul_t  = cyc;
        end
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic junk(input int n);
        repeat (n) begin
            Start      = 1'($urandom_range(0, 1));
            ALUControl = 3'($urandom_range(0, 7));
            SrcA       = $urandom();
            SrcB       = $urandom();
            @(posedge clk); #1;
        end
        Start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("busy", {63'd0, Busy}, {63'd0, busy_exp()});
            if (Done) begin
                if (q.size() == 0) begin
                    check("done_unexp", {63'd0, Done}, 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("done_cyc", 64'(cyc), 64'(mon_e.due));
                    check("result", {32'd0, ALU_Result}, {32'd0, mon_e.res});
                    check("flags", {60'd0, ALUFlags}, {60'd0, mon_e.flg});
                    held_res = mon_e.res;
                    held_flg = mon_e.flg;
                end
            end else begin
                check("hold_res", {32'd0, ALU_Result}, {32'd0, held_res});
                check("hold_flg", {60'd0, ALUFlags}, {60'd0, held_flg});
                if (q.size() > 0 && cyc >= q[0].due) begin
                    check("done_missing", {63'd0, Done}, 64'd1);
                    q.delete(0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        held_res = '0; held_flg = '0;
        mul_on = 1'b0; mul_t = 0;
        Start = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_res", {32'd0, ALU_Result}, 64'd0);
        check("rst_flg", {60'd0, ALUFlags}, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, {4'b0110, 32'h0000_0000});
        issue(3'b001, 32'h8000_0000, 32'h0000_0001, {4'b0011, 32'h7FFF_FFFF});
        issue(3'b001, 32'h0000_0005, 32'h0000_0005, {4'b0110, 32'h0000_0000});
        issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00, {4'b0000, 32'h0000_F000});
        issue(3'b100, 32'h0000_F0F0, 32'h0000_FF00, {4'b0000, 32'h0000_FFF0});
        issue(3'b101, 32'h0000_F0F0, 32'h0000_FF00, {4'b0000, 32'h0000_0FF0});
        issue(3'b011, 32'h0000_F0F0, 32'h0000_FF00, {4'b0000, 32'h0000_FF00});
        issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, {4'b0100, 32'h0000_0000});
        issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, {4'b1001, 32'h8000_0000});
        wait_drain(10);

`ifdef ALU_MULTICYCLE_MUL_EN
        k = cyc;
        issue(3'b110, 32'h0001_0003, 32'h0000_0007, {4'b0000, 32'h0007_0015});
        repeat (4) begin
            SrcA = $urandom(); SrcB = $urandom(); ALUControl = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        ALUControl = 3'b000; SrcA = 32'd1; SrcB = 32'd1; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        while (cyc < k + W) begin
            SrcA = $urandom(); SrcB = $urandom();
            @(posedge clk); #1;
        end
        issue(3'b010, 32'hFFFF_0000, 32'hF0F0_F0F0, {4'b1000, 32'hF0F0_0000});
        wait_drain(10);
`else
        issue(3'b110, 32'hDEAD_BEEF, 32'h0000_0003, {4'b0100, 32'h0000_0000});
        wait_drain(10);
`endif

        issue(3'b000, 32'h0000_1234, 32'h0000_0001, {4'b0000, 32'h0000_1235});
        k = cyc;
`ifdef ALU_MULTICYCLE_MUL_EN
        issue(3'b110, 32'h0000_0123, 32'h0000_0456, model(3'b110, 32'h0000_0123, 32'h0000_0456));
`else
        @(posedge clk); #1;
`endif
        while (cyc < k + 10) begin
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        Start = 1'b1; ALUControl = 3'b000; SrcA = 32'd7; SrcB = 32'd9;
        #1;
        check("abort_done", {63'd0, Done}, 64'd0);
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_res", {32'd0, ALU_Result}, 64'd0);
        check("abort_flg", {60'd0, ALUFlags}, 64'd0);
        q.delete();
        mul_on = 1'b0;
        held_res = '0;
        held_flg = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        Start = 1'b0;
        while (cyc < k + 41) begin
            @(posedge clk); #1;
        end
        issue(3'b000, 32'd2, 32'd3, {4'b0000, 32'd5});
        wait_drain(10);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, model(op, a, b));
            if (op == 3'b110 && MUL_LAT > 1) junk(MUL_LAT - 1);
            else if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_drain(2 * W);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
